// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and
// the instruction memory (slave).
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit: IDLE/REQ/DRAIN/HOLD sequencer with redirect.
// Optional misaligned-redirect trap selected by macro IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  ifetch_unit_if.master       imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [31:0]         pc,
  output logic                fetch_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        misalign_q;

  logic [31:0] redir_tgt;
  logic        redir_bad;
  logic        in_flight;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
`ifdef IFETCH_MISALIGN_TRAP_EN
    redir_tgt = redirect_pc;
    redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
`else
    redir_tgt = {redirect_pc[31:2], 2'b00};
    redir_bad = 1'b0;
`endif
    in_flight = ((state_q == REQ) || (state_q == DRAIN)) && !imem.imem_ack;
  end

`ifndef IFETCH_MISALIGN_TRAP_EN
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      misalign_q   <= 1'b0;
    end else if (misalign_q) begin
      // Parked after a misaligned redirect until the next reset.
      state_q      <= IDLE;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
    end else if (redir_bad) begin
      misalign_q   <= 1'b1;
      state_q      <= IDLE;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q   <= redir_tgt;
      inst_valid_q <= 1'b0;
      if (in_flight) begin
        // Old request must still complete; its data is dropped in DRAIN.
        state_q <= DRAIN;
      end else begin
        state_q     <= REQ;
        imem_req_q  <= 1'b1;
        imem_addr_q <= redir_tgt;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= REQ;
          imem_req_q  <= 1'b1;
          imem_addr_q <= fetch_pc_q;
        end
        REQ: begin
          if (imem.imem_ack) begin
            inst_q       <= imem.imem_rdata;
            pc_q         <= fetch_pc_q;
            fetch_pc_q   <= fetch_pc_q + 32'd4;
            inst_valid_q <= 1'b1;
            imem_req_q   <= 1'b0;
            state_q      <= HOLD;
          end
        end
        DRAIN: begin
          if (imem.imem_ack) begin
            state_q     <= REQ;
            imem_addr_q <= fetch_pc_q;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_q      <= REQ;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            imem_addr_q  <= fetch_pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req   = imem_req_q;
  assign imem.imem_addr  = imem_addr_q;
  assign inst_valid      = inst_valid_q;
  assign inst            = inst_q;
  assign pc              = pc_q;
  assign fetch_misalign  = misalign_q;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory request.
REQ-005 imem_addr  output  32  fetch address.
REQ-006 imem_ack  input  1  memory response valid; imem_rdata is sampled in the cycle where imem_req and imem_ack are both high.
REQ-007 imem_rdata  input  32  instruction word from memory.
REQ-008 stall  input  1  downstream not ready; holds the presented instruction.
REQ-009 redirect  input  1  take redirect_pc; this is the branch/jal/jalr target from the immediate/next-PC logic.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 inst_valid  output  1  inst and pc are valid for decode/immediate generation.
REQ-012 inst  output  32  fetched instruction.
REQ-013 pc  output  32  address of inst.
REQ-014 fetch_misalign  output  1  sticky misaligned-redirect flag; held at 0 when the feature is compiled out.

Function
REQ-015 The block SHALL implement the states IDLE, REQ, DRAIN and HOLD, with an internal 32-bit fetch_pc.
REQ-016 IDLE SHALL go to REQ after one cycle, with imem_req=0.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc.
- imem_addr SHALL stay stable while imem_req=1 and no ack has been received.
REQ-018 In REQ on imem_ack with no redirect, the block SHALL register inst<=imem_rdata, pc<=fetch_pc and fetch_pc<=fetch_pc+4, then enter HOLD.
- inst_valid SHALL become 1 in the next cycle.
REQ-019 In HOLD, imem_req SHALL be 0 and inst_valid SHALL be 1.
- While stall=1, inst and pc SHALL stay unchanged.
- When stall=0, the instruction is consumed: the block SHALL go to REQ and inst_valid SHALL become 0 in the next cycle.
REQ-020 Redirect SHALL have the highest priority in every state.
- fetch_pc<=redirect_pc and inst_valid<=0 in the next cycle.
- Redirect SHALL win over a simultaneous stall.
REQ-021 Redirect in REQ with imem_ack in the same cycle SHALL discard imem_rdata and go to REQ at the new address.
REQ-022 Redirect in REQ without imem_ack SHALL go to DRAIN.
- DRAIN SHALL keep imem_req=1 at the old address until imem_ack, discard that data, then enter REQ at the new address.
- A further redirect in DRAIN SHALL overwrite the pending target.
REQ-023 Redirect in IDLE or HOLD SHALL go to REQ.
REQ-024 stall SHALL have no effect in IDLE, REQ or DRAIN.
REQ-025 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 Throughput SHALL be at most one instruction per two cycles; minimum latency from entering REQ to inst_valid=1 SHALL be 1 cycle after the ack cycle.

Reset
REQ-027 On rst=1, at any time and asynchronously, the block SHALL apply these values:
- state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC
- imem_req=0, imem_addr=RESET_PC, inst_valid=0
- inst=32'h0000_0013 (NOP)
- fetch_misalign=0
REQ-028 Reset during REQ or DRAIN SHALL abandon the outstanding request; an ack arriving after reset while imem_req=0 SHALL be ignored.

Configuration
REQ-029 The feature SHALL be selected by the macro IFETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 SHALL set fetch_misalign=1 (sticky until reset), force inst_valid=0, and park the block in IDLE with no further requests.
- Undefined: redirect_pc[1:0] SHALL be cleared to 2'b00 and fetching SHALL continue; fetch_misalign SHALL be tied to 0.

Verification
REQ-030 Reset, then ack=1 every cycle -> imem_addr 0x0 then 0x4; inst_valid pulses, pc=0x0 then 0x4, with 2 cycles per instruction.
REQ-031 stall=1 for 5 cycles in HOLD with inst=0x00500093 -> inst and pc unchanged, imem_req=0 throughout.
REQ-032 Redirect to 0x100 while in REQ with ack delayed 3 cycles -> the old data is discarded, the next imem_addr is 0x100, and the next valid pc=0x100.
REQ-033 RESET_PC=32'hFFFF_FFFC, fetch two instructions -> pc=0xFFFF_FFFC then 0x0000_0000.
REQ-034 Redirect to 0x102 -> with the macro: fetch_misalign=1 and no imem_req afterwards; without the macro: the next imem_addr is 0x100.
REQ-035 rst asserted mid-DRAIN -> outputs take their reset values immediately, and the first request after reset is to RESET_PC.
